alu_operand_stage: RTL and testbench

- Parametrised successor to the EX-stage operand mux; sits between ID/EX and the ALU / multi-cycle execute units.
- Selects operand 1, operand 2 and store data. Register-file data is forwarded from NFWD selectable sources, then PC, zero, immediate or the constant 4 can be chosen.
- Captures the selected operands in a 2-entry skid buffer with valid/ready handshakes. Forwarded values stay stable while EX stalls, even after MEM/WB have moved on.

---
 rtl/alu_operand_stage_if.sv | 39 +++
 rtl/alu_operand_stage.sv | 108 ++++++++++
 tb/tb_alu_operand_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between ID/EX, the operand stage and the execute units.
// The master drives ops in and consumes operands; the slave is the operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int SELW = 2,
    parameter int TAGW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [SELW-1:0]      fwd_sel_a;
    logic [SELW-1:0]      fwd_sel_b;
    logic [1:0]           op1_mode;
    logic [1:0]           op2_mode;
    logic [TAGW-1:0]      in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      alu_op1;
    logic [XLEN-1:0]      alu_op2;
    logic [XLEN-1:0]      store_data;
    logic [TAGW-1:0]      out_tag;

    modport master (
        output in_valid, rs1_data, rs2_data, pc, imm, fwd_data,
               fwd_sel_a, fwd_sel_b, op1_mode, op2_mode, in_tag, out_ready,
        input  in_ready, out_valid, alu_op1, alu_op2, store_data, out_tag
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, pc, imm, fwd_data,
               fwd_sel_a, fwd_sel_b, op1_mode, op2_mode, in_tag, out_ready,
        output in_ready, out_valid, alu_op1, alu_op2, store_data, out_tag
    );
endinterface

// File: rtl/alu_operand_stage.sv
// EX-stage operand select with forwarding, captured into a 2-entry skid buffer
// so forwarded values stay stable while the execute units stall.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int SELW = 2,
    parameter int TAGW = 8
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    alu_operand_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sd;
        logic [TAGW-1:0] tag;
    } entry_t;

    state_t    r_state;
    entry_t    r_ent [2];

    logic      [XLEN-1:0] w_rs1;
    logic      [XLEN-1:0] w_rs2;
    entry_t    w_new;
    logic      w_in_ready;
    logic      w_out_valid;
    logic      w_push;
    logic      w_pop;

    // Selects beyond NFWD fall back to register-file data.
    always_comb begin
        w_rs1 = bus.rs1_data;
        w_rs2 = bus.rs2_data;
        for (int unsigned k = 1; k <= NFWD; k++) begin
            if (bus.fwd_sel_a == SELW'(k)) w_rs1 = bus.fwd_data[(k-1)*XLEN +: XLEN];
            if (bus.fwd_sel_b == SELW'(k)) w_rs2 = bus.fwd_data[(k-1)*XLEN +: XLEN];
        end
    end

    always_comb begin
        w_new     = '0;
        w_new.sd  = w_rs2;
        w_new.tag = bus.in_tag;
        case (bus.op1_mode)
            2'b00:   w_new.op1 = w_rs1;
            2'b01:   w_new.op1 = bus.pc;
            default: w_new.op1 = '0;
        endcase
        case (bus.op2_mode)
            2'b00:   w_new.op2 = w_rs2;
            2'b10:   w_new.op2 = XLEN'(4);
            default: w_new.op2 = bus.imm;
        endcase
    end

    assign w_in_ready  = rst && (r_state != TWO);
    assign w_out_valid = (r_state != EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Entry 0 is always the head, so outputs come straight from registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= EMPTY;
            r_ent[0] <= '0;
            r_ent[1] <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_ent[0] <= w_new;
                        r_state  <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_ent[0] <= w_new;
                    end else if (w_push) begin
                        r_ent[1] <= w_new;
                        r_state  <= TWO;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_ent[0] <= r_ent[1];
                        r_state  <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.alu_op1    = r_ent[0].op1;
    assign bus.alu_op2    = r_ent[0].op2;
    assign bus.store_data = r_ent[0].sd;
    assign bus.out_tag    = r_ent[0].tag;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, multi-cycle corner sequences,
// and a randomized run against a queue-based reference model.
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int SELW = 2;
    localparam int TAGW = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   failures = 0;

    alu_operand_stage_if #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW), .TAGW(TAGW)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW), .TAGW(TAGW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  m1;
        logic [1:0]  m2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] esd;
    } vec_t;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [7:0]  tag;
    } ent_t;

    vec_t        vecs [7];
    ent_t        q [$];
    logic [31:0] s1;
    logic [31:0] s2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_srcs(input logic [31:0] a, input logic [31:0] b);
        s1 = a;
        s2 = b;
        bus.fwd_data = {b, a};
    endtask

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] src [NFWD+1];
        src[0] = rf;
        src[1] = a;
        src[2] = b;
        if (int'(sel) >= 1 && int'(sel) <= NFWD) return src[sel];
        return rf;
    endfunction

    function automatic ent_t ref_entry();
        ent_t        e;
        logic [31:0] f1;
        logic [31:0] f2;
        f1 = ref_fwd(bus.fwd_sel_a, bus.rs1_data, s1, s2);
        f2 = ref_fwd(bus.fwd_sel_b, bus.rs2_data, s1, s2);
        e.op1 = (bus.op1_mode == 2'd0) ? f1 : (bus.op1_mode == 2'd1) ? bus.pc : 32'd0;
        e.op2 = (bus.op2_mode == 2'd0) ? f2 : (bus.op2_mode == 2'd2) ? 32'd4 : bus.imm;
        e.sd  = f2;
        e.tag = bus.in_tag;
        return e;
    endfunction

    initial begin
        vecs[0] = '{2'd1, 2'd0, 2'd0, 2'd0, 32'hAA,   32'h22,       32'h22};
        vecs[1] = '{2'd2, 2'd1, 2'd0, 2'd0, 32'hBB,   32'hAA,       32'hAA};
        vecs[2] = '{2'd3, 2'd2, 2'd0, 2'd0, 32'h11,   32'hBB,       32'hBB};
        vecs[3] = '{2'd0, 2'd3, 2'd1, 2'd1, 32'h1000, 32'hFFFFFFF0, 32'h22};
        vecs[4] = '{2'd1, 2'd1, 2'd2, 2'd2, 32'h0,    32'h4,        32'hAA};
        vecs[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 32'h0,    32'hFFFFFFF0, 32'hBB};
        vecs[6] = '{2'd0, 2'd0, 2'd0, 2'd0, 32'h11,   32'h22,       32'h22};

        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.rs1_data = 32'h11;
        bus.rs2_data = 32'h22;
        bus.pc = 32'h1000;
        bus.imm = 32'hFFFFFFF0;
        set_srcs(32'hAA, 32'hBB);
        bus.fwd_sel_a = '0;
        bus.fwd_sel_b = '0;
        bus.op1_mode = 2'd0;
        bus.op2_mode = 2'd0;
        bus.in_tag = '0;

        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_op1", 64'(bus.alu_op1), 64'd0);
        chk("rst_op2", 64'(bus.alu_op2), 64'd0);
        chk("rst_sd", 64'(bus.store_data), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // Directed operand selection table
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.fwd_sel_a = vecs[i].sa;
            bus.fwd_sel_b = vecs[i].sb;
            bus.op1_mode = vecs[i].m1;
            bus.op2_mode = vecs[i].m2;
            bus.in_tag = 8'(i + 8'h40);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_op1", i), 64'(bus.alu_op1), 64'(vecs[i].e1));
            chk($sformatf("vec%0d_op2", i), 64'(bus.alu_op2), 64'(vecs[i].e2));
            chk($sformatf("vec%0d_sd", i), 64'(bus.store_data), 64'(vecs[i].esd));
            chk($sformatf("vec%0d_tag", i), 64'(bus.out_tag), 64'(i + 8'h40));
            tick();
            chk($sformatf("vec%0d_drained", i), 64'(bus.out_valid), 64'd0);
        end

        // Stall hold: stored operand must not follow a changing forward source
        bus.out_ready = 1'b0;
        bus.op1_mode = 2'd0;
        bus.op2_mode = 2'd0;
        bus.fwd_sel_a = 2'd0;
        bus.fwd_sel_b = 2'd1;
        set_srcs(32'h55, 32'hBB);
        bus.in_tag = 8'd5;
        bus.in_valid = 1'b1;
        tick();
        chk("stall_op2", 64'(bus.alu_op2), 64'h55);
        chk("stall_tag", 64'(bus.out_tag), 64'd5);
        chk("stall_ready_one", 64'(bus.in_ready), 64'd1);
        set_srcs(32'h99, 32'hBB);
        bus.in_tag = 8'd6;
        tick();
        bus.in_valid = 1'b0;
        chk("stall_hold_op2", 64'(bus.alu_op2), 64'h55);
        chk("stall_full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("stall_hold2_op2", 64'(bus.alu_op2), 64'h55);
        chk("stall_hold2_tag", 64'(bus.out_tag), 64'd5);
        bus.out_ready = 1'b1;
        tick();
        chk("stall_drain_tag", 64'(bus.out_tag), 64'd6);
        chk("stall_drain_op2", 64'(bus.alu_op2), 64'h99);
        chk("stall_drain_valid", 64'(bus.out_valid), 64'd1);
        tick();
        chk("stall_empty", 64'(bus.out_valid), 64'd0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_tag = 8'(i);
            chk($sformatf("stream%0d_ready", i), 64'(bus.in_ready), 64'd1);
            tick();
            chk($sformatf("stream%0d_tag", i), 64'(bus.out_tag), 64'(i));
            chk($sformatf("stream%0d_valid", i), 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_end", 64'(bus.out_valid), 64'd0);

        // Flush from TWO with a concurrent op, then from ONE with a push offered
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_tag = 8'hA0;
        tick();
        bus.in_tag = 8'hA1;
        tick();
        chk("flush_full", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        bus.in_tag = 8'hA2;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("flush_stays_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_tag = 8'hB0;
        tick();
        bus.in_tag = 8'hB1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_beats_push", 64'(bus.out_valid), 64'd0);
        tick();
        chk("flush_beats_push2", 64'(bus.out_valid), 64'd0);

        // Reset mid-operation
        bus.fwd_sel_a = 2'd0;
        bus.rs1_data = 32'hDEAD;
        bus.in_tag = 8'h33;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rmid_op1", 64'(bus.alu_op1), 64'hDEAD);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("rmid_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        chk("rmid_valid", 64'(bus.out_valid), 64'd0);
        chk("rmid_op1_zero", 64'(bus.alu_op1), 64'd0);
        chk("rmid_ready_held", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        bus.rs1_data = 32'h1234;
        bus.in_tag = 8'h77;
        #1;
        chk("rmid_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("rmid_push_valid", 64'(bus.out_valid), 64'd1);
        chk("rmid_push_op1", 64'(bus.alu_op1), 64'h1234);
        chk("rmid_push_tag", 64'(bus.out_tag), 64'h77);
        bus.out_ready = 1'b1;
        tick();

        // Randomized run against the queue model
        q.delete();
        for (int c = 0; c < 400; c++) begin
            bit push;
            bit pop;
            ent_t e;
            rst = ($urandom_range(0, 60) != 0);
            flush = ($urandom_range(0, 25) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
            bus.pc = $urandom;
            bus.imm = $urandom;
            set_srcs($urandom, $urandom);
            bus.fwd_sel_a = 2'($urandom_range(0, 3));
            bus.fwd_sel_b = 2'($urandom_range(0, 3));
            bus.op1_mode = 2'($urandom_range(0, 3));
            bus.op2_mode = 2'($urandom_range(0, 3));
            bus.in_tag = 8'($urandom);
            #1;
            chk("rnd_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("rnd_ready", 64'(bus.in_ready), 64'(rst && q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_op1", 64'(bus.alu_op1), 64'(q[0].op1));
                chk("rnd_op2", 64'(bus.alu_op2), 64'(q[0].op2));
                chk("rnd_sd", 64'(bus.store_data), 64'(q[0].sd));
                chk("rnd_tag", 64'(bus.out_tag), 64'(q[0].tag));
            end
            if (!rst || flush) begin
                q.delete();
            end else begin
                push = bus.in_valid && (q.size() < 2);
                pop = (q.size() > 0) && bus.out_ready;
                e = ref_entry();
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
